// File: rtl/packet_pb_feeder.sv
// rtl/packet_pb_feeder.sv - config-chain loaded descriptor buffer serving packet_request/packet_out handshakes
// Optional build macro PB_FEEDER_LOOP_EN: non-destructive reads, stored list replays indefinitely.
module packet_pb_feeder #(
    parameter int DEPTH     = 64,
    parameter int LOG_DEPTH = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    output logic        error,
    output logic        is_quiescent,
    input  logic [15:0] config_in,
    input  logic        config_in_valid,
    output logic [15:0] config_out,
    output logic        config_out_valid,
    input  logic        packet_request,
    output logic [31:0] packet_out,
    output logic        packet_out_valid
);
    localparam int CW = LOG_DEPTH + 1;
    localparam logic [CW-1:0]        FULL    = CW'(DEPTH);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE = LOG_DEPTH'(1);

    typedef enum logic [1:0] {S_CNT, S_LO, S_HI, S_PASS} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        k_reg, k_nx;
    logic [CW-1:0]        ld_cnt, ld_cnt_nx;
    logic [15:0]          lo_reg, lo_nx;
    logic [31:0]          mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [CW-1:0]        count, count_nx;
    logic                 pending, pending_nx;
    logic                 wr_hit, wr_en, wr_drop, k_over, cfg_fwd;
    logic                 req_eff, serve, quiet_nx;
    logic [31:0]          wr_data, rd_data;

    // Load FSM: consumes the count word and K lo/hi pairs, then passes the chain through.
    always_comb begin
        state_nx  = state;
        k_nx      = k_reg;
        ld_cnt_nx = ld_cnt;
        lo_nx     = lo_reg;
        wr_hit    = 1'b0;
        k_over    = 1'b0;
        cfg_fwd   = 1'b0;
        if (config_in_valid) begin
            case (state)
                S_CNT: begin
                    k_nx      = config_in[LOG_DEPTH:0];
                    ld_cnt_nx = '0;
                    k_over    = config_in[LOG_DEPTH:0] > FULL;
                    state_nx  = (config_in[LOG_DEPTH:0] == '0) ? S_PASS : S_LO;
                end
                S_LO: begin
                    lo_nx    = config_in;
                    state_nx = S_HI;
                end
                S_HI: begin
                    wr_hit    = 1'b1;
                    ld_cnt_nx = ld_cnt + CW'(1);
                    state_nx  = (ld_cnt + CW'(1) == k_reg) ? S_PASS : S_LO;
                end
                default: cfg_fwd = 1'b1;
            endcase
        end
    end

    // Serve path; an empty buffer being written this cycle is bypassed straight to the output.
    always_comb begin
        wr_data = {config_in, lo_reg};
        wr_en   = wr_hit & (ld_cnt < FULL) & (count != FULL);
        wr_drop = wr_hit & ~wr_en;
        req_eff = pending | packet_request;
        serve   = req_eff & enable & ((count != '0) | wr_en);
        rd_data = (count == '0) ? wr_data : mem[rd_ptr];
        pending_nx = req_eff & ~serve;
`ifdef PB_FEEDER_LOOP_EN
        count_nx  = count + CW'(wr_en);
        rd_ptr_nx = (({1'b0, rd_ptr} + CW'(1)) >= count_nx) ? '0 : rd_ptr + PTR_ONE;
        quiet_nx  = ~pending_nx & (state_nx == S_PASS);
`else
        count_nx  = count + CW'(wr_en) - CW'(serve);
        rd_ptr_nx = rd_ptr + PTR_ONE;
        quiet_nx  = ~pending_nx & (count_nx == '0) & (state_nx == S_PASS);
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_CNT;
            k_reg            <= '0;
            ld_cnt           <= '0;
            lo_reg           <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            pending          <= 1'b0;
            error            <= 1'b0;
            is_quiescent     <= 1'b1;
            config_out       <= '0;
            config_out_valid <= 1'b0;
            packet_out       <= '0;
            packet_out_valid <= 1'b0;
        end else begin
            state            <= state_nx;
            k_reg            <= k_nx;
            ld_cnt           <= ld_cnt_nx;
            lo_reg           <= lo_nx;
            count            <= count_nx;
            pending          <= pending_nx;
            is_quiescent     <= quiet_nx;
            error            <= error | k_over | wr_drop | (packet_request & pending);
            config_out_valid <= cfg_fwd;
            packet_out_valid <= serve;
            if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
            if (serve)   rd_ptr <= rd_ptr_nx;
            if (cfg_fwd) config_out <= config_in;
            if (serve)   packet_out <= rd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_packet_pb_feeder.sv
// tb/tb_packet_pb_feeder.sv - scoreboard bench for packet_pb_feeder
module tb_packet_pb_feeder;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        error, is_quiescent;
    logic [15:0] config_in = '0;
    logic        config_in_valid = 1'b0;
    logic [15:0] config_out;
    logic        config_out_valid;
    logic        packet_request = 1'b0;
    logic [31:0] packet_out;
    logic        packet_out_valid;

    int checks = 0;
    int fails  = 0;
    logic [31:0] pq[$];
    logic [15:0] cq[$];

    packet_pb_feeder #(.DEPTH(64), .LOG_DEPTH(6)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .error(error),
        .is_quiescent(is_quiescent), .config_in(config_in), .config_in_valid(config_in_valid),
        .config_out(config_out), .config_out_valid(config_out_valid),
        .packet_request(packet_request), .packet_out(packet_out),
        .packet_out_valid(packet_out_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (packet_out_valid) begin
            chk("pkt_expected", 32'(pq.size() != 0), 32'd1);
            if (pq.size() != 0) chk("pkt_data", packet_out, pq.pop_front());
        end
        if (config_out_valid) begin
            chk("cfg_expected", 32'(cq.size() != 0), 32'd1);
            if (cq.size() != 0) chk("cfg_data", 32'(config_out), 32'(cq.pop_front()));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input logic [15:0] w, input bit fwd);
        config_in       = w;
        config_in_valid = 1'b1;
        if (fwd) cq.push_back(w);
        step();
        config_in_valid = 1'b0;
    endtask

    task automatic req();
        packet_request = 1'b1;
        step();
        packet_request = 1'b0;
    endtask

    task automatic do_reset();
        pq.delete();
        cq.delete();
        reset_n = 1'b0;
        #1;
        chk("rst_quiescent", 32'(is_quiescent), 32'd1);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_pkt_valid", 32'(packet_out_valid), 32'd0);
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        step();
        chk("init_quiescent", 32'(is_quiescent), 32'd1);
        chk("init_pkt_out", packet_out, 32'd0);
        chk("init_cfg_out", 32'(config_out), 32'd0);
        chk("init_cfg_valid", 32'(config_out_valid), 32'd0);
        do_reset();

`ifdef PB_FEEDER_LOOP_EN
        cfg(16'd2, 0);
        cfg(16'h1111, 0); cfg(16'hAAAA, 0);
        cfg(16'h2222, 0); cfg(16'hBBBB, 0);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pq.push_back((i % 2 == 0) ? 32'hAAAA1111 : 32'hBBBB2222);
            req();
            chk("loop_valid", 32'(packet_out_valid), 32'd1);
            step();
        end
        chk("loop_quiescent", 32'(is_quiescent), 32'd1);
        chk("loop_error", 32'(error), 32'd0);
`else
        // T1: two descriptors loaded, following word forwarded
        cfg(16'd2, 0);
        cfg(16'h1111, 0); cfg(16'hAAAA, 0); pq.push_back(32'hAAAA1111);
        cfg(16'h2222, 0); cfg(16'hBBBB, 0); pq.push_back(32'hBBBB2222);
        cfg(16'h5A5A, 1);
        chk("t1_fwd_valid", 32'(config_out_valid), 32'd1);
        step();
        chk("t1_fwd_drop", 32'(config_out_valid), 32'd0);
        chk("t1_not_quiet", 32'(is_quiescent), 32'd0);

        // T2: serve with one-cycle latency, output held after strobe
        enable = 1'b1;
        req();
        chk("t2_valid1", 32'(packet_out_valid), 32'd1);
        step();
        chk("t2_strobe_len", 32'(packet_out_valid), 32'd0);
        chk("t2_hold", packet_out, 32'hAAAA1111);
        step();
        req();
        chk("t2_valid2", 32'(packet_out_valid), 32'd1);
        step();
        chk("t2_quiet", 32'(is_quiescent), 32'd1);
        chk("t2_error", 32'(error), 32'd0);
        chk("t2_sb_empty", 32'(pq.size()), 32'd0);

        // T3: request while empty, served right after the high word lands
        do_reset();
        enable = 1'b1;
        req();
        chk("t3_wait", 32'(packet_out_valid), 32'd0);
        step(); step();
        cfg(16'd1, 0);
        cfg(16'h0003, 0);
        pq.push_back(32'h00010003);
        cfg(16'h0001, 0);
        chk("t3_valid", 32'(packet_out_valid), 32'd1);
        chk("t3_error", 32'(error), 32'd0);
        step();
        chk("t3_strobe_len", 32'(packet_out_valid), 32'd0);

        // T4: double request while empty -> sticky error, one serve
        do_reset();
        enable = 1'b1;
        packet_request = 1'b1;
        step(); step();
        packet_request = 1'b0;
        chk("t4_error", 32'(error), 32'd1);
        cfg(16'd2, 0);
        cfg(16'h0C01, 0);
        pq.push_back(32'h0D010C01);
        cfg(16'h0D01, 0);
        chk("t4_valid", 32'(packet_out_valid), 32'd1);
        pq.push_back(32'h0D020C02);
        cfg(16'h0C02, 0);
        cfg(16'h0D02, 0);
        chk("t4_no_second", 32'(packet_out_valid), 32'd0);
        step();
        chk("t4_no_second_b", 32'(packet_out_valid), 32'd0);
        chk("t4_sticky", 32'(error), 32'd1);
        chk("t4_unserved", 32'(pq.size()), 32'd1);

        // T5: K = DEPTH+1, last descriptor dropped, full drain wraps pointers
        do_reset();
        enable = 1'b0;
        cfg(16'd65, 0);
        chk("t5_error", 32'(error), 32'd1);
        for (int i = 0; i < 65; i++) begin
            cfg(16'(i), 0);
            cfg(16'hC000 | 16'(i), 0);
            if (i < 64) pq.push_back({16'hC000 | 16'(i), 16'(i)});
        end
        cfg(16'h0F0F, 1);
        step();
        enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            req();
            chk("t5_valid", 32'(packet_out_valid), 32'd1);
        end
        step();
        chk("t5_quiet", 32'(is_quiescent), 32'd1);
        req();
        chk("t5_no_extra", 32'(packet_out_valid), 32'd0);
        chk("t5_sb_empty", 32'(pq.size()), 32'd0);
`endif

        // Reset mid-S_LO: next chain word is taken as K
        do_reset();
        enable = 1'b0;
        cfg(16'd2, 0);
        do_reset();
        cfg(16'd1, 0);
        cfg(16'h4444, 0);
        pq.push_back(32'h55554444);
        cfg(16'h5555, 0);
        cfg(16'h7777, 1);
        enable = 1'b1;
        req();
        chk("rst_lo_valid", 32'(packet_out_valid), 32'd1);
        step();
        chk("rst_lo_sb", 32'(pq.size()), 32'd0);
        chk("rst_lo_cfg_sb", 32'(cq.size()), 32'd0);
        chk("rst_lo_error", 32'(error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
